// File: rtl/nco_lut_reader.sv
// Quarter-wave sine LUT reader: folds a phase word into a quarter-table lookup and emits a
// signed sample through a 3-stage valid/ready pipeline that stalls as a whole.
module nco_lut_reader #(
  parameter int unsigned PHASE_W = 8,
  parameter int unsigned DATA_W  = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PHASE_W-1:0]       address,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] sample,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int unsigned IdxW = PHASE_W - 2;
  localparam int unsigned N    = 2 ** IdxW;
  localparam int unsigned RomW = DATA_W - 1;

  typedef logic [N-1:0][RomW-1:0] rom_t;

  // Table is built at elaboration; sampling at (k+0.5) keeps the fold symmetric.
  function automatic rom_t gen_rom();
    rom_t t;
    real  amp;
    real  ph;
    amp = real'((2 ** (DATA_W - 1)) - 1);
    for (int k = 0; k < int'(N); k++) begin
      ph   = (3.14159265358979323846 / 2.0) * (real'(k) + 0.5) / real'(N);
      t[k] = RomW'($rtoi(amp * $sin(ph) + 0.5));
    end
    return t;
  endfunction

  localparam rom_t Rom = gen_rom();

  logic              adv;
  logic [1:0]        quad;
  logic [IdxW-1:0]   idx_in;
  logic [DATA_W-1:0] mag;

  logic              v1_d, v1_q;
  logic [IdxW-1:0]   idx1_d, idx1_q;
  logic              neg1_d, neg1_q;
  logic              v2_d, v2_q;
  logic [RomW-1:0]   data2_d, data2_q;
  logic              neg2_d, neg2_q;
  logic              v3_d, v3_q;
  logic [DATA_W-1:0] sample3_d, sample3_q;

  always_comb begin
    adv    = !v3_q || out_ready;
    quad   = address[PHASE_W-1 -: 2];
    idx_in = address[IdxW-1:0];
    mag    = {1'b0, data2_q};

    v1_d      = v1_q;
    idx1_d    = idx1_q;
    neg1_d    = neg1_q;
    v2_d      = v2_q;
    data2_d   = data2_q;
    neg2_d    = neg2_q;
    v3_d      = v3_q;
    sample3_d = sample3_q;

    if (adv) begin
      v1_d      = in_valid;
      // Odd quadrants read the table backwards; N-1-i is the bitwise complement of i.
      idx1_d    = quad[0] ? ~idx_in : idx_in;
      neg1_d    = quad[1];
      v2_d      = v1_q;
      data2_d   = Rom[idx1_q];
      neg2_d    = neg1_q;
      v3_d      = v2_q;
      sample3_d = neg2_q ? -mag : mag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      idx1_q    <= '0;
      neg1_q    <= 1'b0;
      v2_q      <= 1'b0;
      data2_q   <= '0;
      neg2_q    <= 1'b0;
      v3_q      <= 1'b0;
      sample3_q <= '0;
    end else begin
      v1_q      <= v1_d;
      idx1_q    <= idx1_d;
      neg1_q    <= neg1_d;
      v2_q      <= v2_d;
      data2_q   <= data2_d;
      neg2_q    <= neg2_d;
      v3_q      <= v3_d;
      sample3_q <= sample3_d;
    end
  end

  assign in_ready  = adv;
  assign sample    = sample3_q;
  assign out_valid = v3_q;

endmodule

// File: tb/tb_nco_lut_reader.sv
// Bench for nco_lut_reader: directed checks plus a randomized run scored against a
// sine model computed directly from the quadrant rules.
module tb_nco_lut_reader;

  localparam int unsigned PHASE_W = 8;
  localparam int unsigned DATA_W  = 12;
  localparam int          NQ      = 2 ** (PHASE_W - 2);

  logic                     clk;
  logic                     rst_n;
  logic [PHASE_W-1:0]       address;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] sample;
  logic                     out_valid;
  logic                     out_ready;

  int n_checks = 0;
  int n_errors = 0;
  int sb_q[$];
  int got[256];

  nco_lut_reader #(
    .PHASE_W(PHASE_W),
    .DATA_W (DATA_W)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .address  (address),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sample   (sample),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_sample(input int addr);
    int  quadrant;
    int  k;
    int  m;
    real amp;
    quadrant = (addr / NQ) % 4;
    k        = addr % NQ;
    if (quadrant == 1 || quadrant == 3) k = NQ - 1 - k;
    amp = real'((2 ** (DATA_W - 1)) - 1);
    m   = $rtoi(amp * $sin((3.14159265358979 / 2.0) * (real'(k) + 0.5) / real'(NQ)) + 0.5);
    return (quadrant >= 2) ? -m : m;
  endfunction

  // Scoreboard: every accepted address must come out exactly once, in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) sb_q.push_back(ref_sample(int'(address)));
      if (out_valid && out_ready) begin
        check_eq("sb_nonempty", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) check_eq("sb_sample", int'(sample), sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int exp6[6];
    int addr6[6];
    int n;
    int idx;
    int outn;
    int stall_cnt;
    bit seen_first;
    int a_new;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    address   = '0;
    out_ready = 1'b1;
    #12;
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_sample", int'(sample), 0);
    check_eq("rst_in_ready", int'(in_ready), 1);
    tick();
    rst_n = 1'b1;
    tick();

    // Quadrant landmarks
    addr6 = '{0, 63, 64, 128, 192, 255};
    exp6  = '{25, 2047, 2047, -25, -2047, -25};
    for (int c = 0; c < 9; c++) begin
      in_valid = (c < 6);
      address  = (c < 6) ? PHASE_W'(addr6[c]) : '0;
      @(negedge clk);
      if (c < 3) begin
        check_eq("lm_lat_ov", int'(out_valid), 0);
      end else begin
        check_eq("lm_ov", int'(out_valid), 1);
        check_eq("lm_sample", int'(sample), exp6[c-3]);
      end
      tick();
    end
    idle(4);

    // Full sweep and symmetry
    n = 0;
    for (int c = 0; c < 300 && n < 256; c++) begin
      in_valid = (c < 256);
      address  = PHASE_W'(c);
      @(negedge clk);
      if (out_valid) begin
        got[n] = int'(sample);
        n++;
      end
      tick();
    end
    check_eq("sweep_count", n, 256);
    for (int p = 0; p < 128; p++) begin
      check_eq("sym_half", got[p], -got[p+128]);
      check_eq("sym_mirror", got[p], got[127-p]);
    end
    idle(4);

    // Backpressure stall
    idx        = 0;
    outn       = 0;
    stall_cnt  = 0;
    seen_first = 1'b0;
    for (int c = 0; c < 40 && outn < 4; c++) begin
      if (out_valid) seen_first = 1'b1;
      out_ready = seen_first && (stall_cnt >= 5);
      in_valid  = (idx < 4);
      address   = PHASE_W'(10 + idx);
      @(negedge clk);
      if (seen_first && stall_cnt < 5) begin
        check_eq("stall_ov", int'(out_valid), 1);
        check_eq("stall_sample", int'(sample), ref_sample(10));
        check_eq("stall_in_ready", int'(in_ready), 0);
        stall_cnt++;
      end
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        check_eq("stall_order", int'(sample), ref_sample(10 + outn));
        outn++;
      end
      tick();
    end
    check_eq("stall_delivered", outn, 4);
    idle(4);

    // Bubble propagation
    for (int c = 0; c < 7; c++) begin
      in_valid = (c < 4) && (c % 2 == 0);
      address  = PHASE_W'($urandom_range(255));
      @(negedge clk);
      if (c >= 3) check_eq("bubble_ov", int'(out_valid), int'((c - 3) % 2 == 0));
      tick();
    end
    idle(4);

    // Mid-stream reset with three samples in flight
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      address  = PHASE_W'(20 + c);
      tick();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    sb_q.delete();
    #1;
    check_eq("mrst_ov", int'(out_valid), 0);
    check_eq("mrst_sample", int'(sample), 0);
    check_eq("mrst_in_ready", int'(in_ready), 1);
    tick();
    rst_n = 1'b1;
    a_new = 77;
    for (int c = 0; c < 4; c++) begin
      in_valid = (c == 0);
      address  = PHASE_W'(a_new);
      @(negedge clk);
      if (c < 3) begin
        check_eq("mrst_no_stale", int'(out_valid), 0);
      end else begin
        check_eq("mrst_new_ov", int'(out_valid), 1);
        check_eq("mrst_new_sample", int'(sample), ref_sample(a_new));
      end
      tick();
    end
    idle(4);

    // Random traffic against the scoreboard
    for (int c = 0; c < 10000; c++) begin
      in_valid  = $urandom_range(1);
      out_ready = $urandom_range(1);
      address   = PHASE_W'($urandom_range(255));
      tick();
    end
    idle(10);
    check_eq("sb_drain", int'(sb_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
